histogram_scan: RTL and testbench
=================================

# histogram_scan

Downstream reader for the streaming histogram. On a start request it sweeps every bin through the histogram's query port, one query per cycle, absorbing the fixed query latency. It reduces the returned counts to a total sample count and a mode: the bin with the highest count, with ties resolved to the lowest word. Results are held for the control or reporting logic until the next scan.

## Interface
- `word_width`, 12: bin index width; the histogram has 2**word_width bins.
- `count_width`, 48: per-bin counter width returned by the histogram.
- `query_latency`, 3: cycles from the clock edge that launches a query to the clock edge after which `query_count` is valid for it.
- `total_width`, derived, `count_width + word_width`: accumulator width; cannot overflow.

Ports:
- `clk`, in, 1: rising-edge clock. The block has one clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: request a scan; sampled only in IDLE or DONE.
- `busy`, out, 1: scan in progress.
- `done`, out, 1: one-cycle pulse when results become valid.
- `query_valid`, out, 1: query strobe to the histogram.
- `query_word`, out, `word_width`: bin being queried.
- `query_count`, in, `count_width`: histogram response.
- `total_count`, out, `total_width`: sum of all bin counts.
- `mode_word`, out, `word_width`: index of the maximum bin.
- `mode_count`, out, `count_width`: count of `mode_word`.
- `nonzero_bins`, out, `word_width+1`: number of bins with a nonzero count (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE or DONE, `start`=1: clear the accumulators, go to ISSUE.
  - ISSUE: drive `query_valid`=1 with `query_word`=0,1,…,2**word_width-1, one per cycle. After the last word, go to DRAIN.
  - DRAIN: `query_valid`=0. When the last response is retired, go to DONE.
  - DONE: outputs are held. `start` begins a new scan.
- Return tracking: a valid/word delay line of depth `query_latency` tags each `query_count` arrival with its bin.
- Retire, per returned bin:
  - `total += count`, zero-extended.
  - If `count > mode_count` (strict), load `mode_word`/`mode_count`. Lowest index wins ties.
  - Bin 0 always loads the mode, so an all-zero histogram gives mode 0/0.
- `start` is ignored while `busy`.
- Reset mid-scan: all state clears immediately and the scan is abandoned. The next scan needs a new `start`.
- The histogram must not be streamed during a scan. The result reflects per-bin reads at query time; coherency is not guaranteed.

## Timing
- Reset values: `busy`=0, `done`=0, `query_valid`=0, `query_word`=0, `total_count`=0, `mode_word`=0, `mode_count`=0, `nonzero_bins`=0. FSM is in IDLE.
- All outputs are registered.
- Let E0 be the edge that samples `start`=1.
  - `query_valid`/`query_word`=k are visible after edge Ek, for 0 ≤ k < N, where N = 2**word_width.
  - `query_count` for word k is captured at edge Ek+query_latency+1.
- `done` and final results become visible after edge E(N+query_latency), i.e. 4099 cycles with defaults.
- `busy` is high from after E0 and drops in the same cycle `done` rises.
- `done` lasts exactly one cycle. Results are stable until the edge after the next accepted `start`.

## Configuration
- `HIST_SCAN_NONZERO_EN` defined: `nonzero_bins` counts retired bins with `count != 0`. It is cleared on start, is valid with `done`, and ranges 0..N.
- Not defined: the counter logic is omitted and `nonzero_bins` is tied to 0.

## Structure
- Package `hist_pkg` holds:
  - default `word_width`/`count_width`/`query_latency` constants;
  - the FSM state enum `hist_scan_state_t`;
  - the `total_width` derivation function.
- One sub-module, `hist_query_delay`: a parameterised valid+word shift register of depth `query_latency`. It is reset by `rst_n` and reused by other query consumers.
- The top level holds the FSM, the address counter and the reduction registers.

## Test plan
Benches use the real streaming histogram, or a model with 3-cycle query latency.
- Empty histogram, start → `done` 4099 cycles after the start edge; total=0, mode_word=0x000, mode_count=0, nonzero=0.
- One stream beat of eight words all 0x123 → total=8, mode_word=0x123, mode_count=8, nonzero=1.
- Bins 0x020 and 0x010 each hold 5, 0xFFF holds 4 → mode_word=0x010, mode_count=5, total=14, nonzero=3.
- `start` held high for the whole scan → exactly one scan. `query_word` runs 0x000..0xFFF once, with no gaps and no repeats, and `done` pulses once.
- `rst_n` dropped at cycle 2000 of a scan → all outputs 0 asynchronously. A new start then yields correct results.
- Back-to-back scans: `start` in the `done` cycle → the new scan begins, and results are identical when the histogram is unchanged.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared constants, FSM state type and width helper for the histogram scan reader.
// Consumers import this package to stay in step with the histogram's geometry.
package hist_pkg;

    localparam int WORD_WIDTH    = 12;
    localparam int COUNT_WIDTH   = 48;
    localparam int QUERY_LATENCY = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } hist_scan_state_t;

    // Summing 2**ww counts of cw bits needs ww extra bits to never overflow.
    function automatic int calc_total_width(input int cw, input int ww);
        return cw + ww;
    endfunction

endpackage

// File: rtl/hist_query_delay.sv
// Valid+word shift line that tags each histogram query response with its bin.
// Depth equals the histogram's query latency; depth must be at least 1.
module hist_query_delay
    import hist_pkg::*;
#(
    parameter int word_width = WORD_WIDTH,
    parameter int depth      = QUERY_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [word_width-1:0] word_i,
    output logic                  valid_o,
    output logic [word_width-1:0] word_o
);

    logic [depth-1:0]      valid_q;
    logic [word_width-1:0] word_q [depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                valid_q[i] <= 1'b0;
                word_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            word_q[0]  <= word_i;
            for (int i = 1; i < depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                word_q[i]  <= word_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[depth-1];
    assign word_o  = word_q[depth-1];

endmodule

// File: rtl/histogram_scan.sv
// Sweeps every histogram bin through the query port and reduces the counts to total and mode.
// Define HIST_SCAN_NONZERO_EN to also count bins holding a nonzero count.
module histogram_scan
    import hist_pkg::*;
#(
    parameter  int word_width    = WORD_WIDTH,
    parameter  int count_width   = COUNT_WIDTH,
    parameter  int query_latency = QUERY_LATENCY,
    localparam int total_width   = calc_total_width(count_width, word_width)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   query_valid,
    output logic [word_width-1:0]  query_word,
    input  logic [count_width-1:0] query_count,
    output logic [total_width-1:0] total_count,
    output logic [word_width-1:0]  mode_word,
    output logic [count_width-1:0] mode_count,
    output logic [word_width:0]    nonzero_bins
);

    hist_scan_state_t       state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   query_valid_q;
    logic [word_width-1:0]  query_word_q;
    logic [total_width-1:0] total_q,      total_d;
    logic [word_width-1:0]  mode_word_q,  mode_word_d;
    logic [count_width-1:0] mode_count_q, mode_count_d;

    logic                   ret_valid;
    logic [word_width-1:0]  ret_word;
    logic                   last_retire;
    logic                   start_accept;

    hist_query_delay #(
        .word_width (word_width),
        .depth      (query_latency)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (query_valid_q),
        .word_i  (query_word_q),
        .valid_o (ret_valid),
        .word_o  (ret_word)
    );

    assign start_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign last_retire  = ret_valid && (ret_word == '1);

    // Bin 0 always seeds the mode so later bins only replace it on a strictly larger count.
    always_comb begin
        total_d      = total_q;
        mode_word_d  = mode_word_q;
        mode_count_d = mode_count_q;
        if (ret_valid) begin
            total_d = total_q + total_width'(query_count);
            if ((ret_word == '0) || (query_count > mode_count_q)) begin
                mode_word_d  = ret_word;
                mode_count_d = query_count;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            query_valid_q <= 1'b0;
            query_word_q  <= '0;
            total_q       <= '0;
            mode_word_q   <= '0;
            mode_count_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_ISSUE;
                        busy_q        <= 1'b1;
                        query_valid_q <= 1'b1;
                        query_word_q  <= '0;
                        total_q       <= '0;
                        mode_word_q   <= '0;
                        mode_count_q  <= '0;
                    end
                end
                S_ISSUE: begin
                    total_q      <= total_d;
                    mode_word_q  <= mode_word_d;
                    mode_count_q <= mode_count_d;
                    if (query_word_q == '1) begin
                        state_q       <= S_DRAIN;
                        query_valid_q <= 1'b0;
                        query_word_q  <= '0;
                    end else begin
                        query_word_q <= query_word_q + word_width'(1);
                    end
                end
                S_DRAIN: begin
                    total_q      <= total_d;
                    mode_word_q  <= mode_word_d;
                    mode_count_q <= mode_count_d;
                    if (last_retire) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef HIST_SCAN_NONZERO_EN
    logic [word_width:0] nonzero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonzero_q <= '0;
        end else if (start_accept) begin
            nonzero_q <= '0;
        end else if (ret_valid && (query_count != '0)) begin
            nonzero_q <= nonzero_q + (word_width+1)'(1);
        end
    end

    assign nonzero_bins = nonzero_q;
`else
    assign nonzero_bins = '0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign query_valid = query_valid_q;
    assign query_word  = query_word_q;
    assign total_count = total_q;
    assign mode_word   = mode_word_q;
    assign mode_count  = mode_count_q;

endmodule

// File: tb/tb_histogram_scan.sv
// Self-checking bench for histogram_scan: 3-cycle histogram model, table vectors,
// randomized fills against a whole-array reference, and multi-cycle corner sequences.
module tb_histogram_scan;
    import hist_pkg::*;

    localparam int N       = 1 << WORD_WIDTH;
    localparam int EXP_LAT = N + QUERY_LATENCY;
`ifdef HIST_SCAN_NONZERO_EN
    localparam bit NZ_EN = 1'b1;
`else
    localparam bit NZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        query_valid;
    logic [11:0] query_word;
    logic [47:0] query_count;
    logic [59:0] total_count;
    logic [11:0] mode_word;
    logic [47:0] mode_count;
    logic [12:0] nonzero_bins;

    histogram_scan dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .query_valid  (query_valid),
        .query_word   (query_word),
        .query_count  (query_count),
        .total_count  (total_count),
        .mode_word    (mode_word),
        .mode_count   (mode_count),
        .nonzero_bins (nonzero_bins)
    );

    always #5 clk = ~clk;

    // Histogram stand-in: three register stages from the sampled query to query_count.
    logic [47:0] histMem [N];
    logic [47:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= histMem[query_word];
        p2 <= p1;
        p3 <= p2;
    end
    assign query_count = p3;

    int testsRun = 0;
    int failed   = 0;

    logic [63:0] modelTotal;
    logic [11:0] modelWord;
    logic [47:0] modelCount;
    logic [12:0] modelNz;

    typedef struct {
        int              nPairs;
        logic [2:0][11:0] w;
        logic [2:0][47:0] c;
        logic [59:0]     expTotal;
        logic [11:0]     expWord;
        logic [47:0]     expCount;
        logic [12:0]     expNz;
    } vec_t;
    vec_t vecs[3];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < N; i++) histMem[i] = '0;
    endtask

    // Reference: total by summation, mode as the first index holding the maximum value.
    task automatic computeModel();
        logic [47:0] maxVal;
        maxVal = '0;
        modelTotal = '0;
        modelNz = '0;
        for (int i = 0; i < N; i++) begin
            modelTotal += 64'(histMem[i]);
            if (histMem[i] > maxVal) maxVal = histMem[i];
            if (histMem[i] != 0) modelNz++;
        end
        modelCount = maxVal;
        modelWord = '0;
        for (int i = N - 1; i >= 0; i--)
            if (histMem[i] == maxVal) modelWord = 12'(i);
        if (!NZ_EN) modelNz = '0;
    endtask

    task automatic applyStimulus(input bit holdStart, input bit skipRaise, input bit chainNext,
                                 output int latency, output int validCount, output int wordErrs,
                                 output logic busyAtDone);
        int  n;
        int  expectWord;
        bit  seen;
        latency = -1;
        validCount = 0;
        wordErrs = 0;
        expectWord = 0;
        seen = 1'b0;
        busyAtDone = 1'bx;
        n = 0;
        if (!skipRaise) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        while (!seen && n < 5000) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            if (query_valid) begin
                if (query_word != 12'(expectWord)) wordErrs++;
                expectWord++;
                validCount++;
            end
            if (done) begin
                seen = 1'b1;
                latency = n;
                busyAtDone = busy;
                start = chainNext;
            end else begin
                @(posedge clk);
                n++;
            end
        end
    endtask

    task automatic checkScan(input string tag, input int latency, input int validCount,
                             input int wordErrs, input logic busyAtDone);
        checkOutput($sformatf("%s.latency", tag), 64'(latency), 64'(EXP_LAT));
        checkOutput($sformatf("%s.queries", tag), 64'(validCount), 64'(N));
        checkOutput($sformatf("%s.wordErrs", tag), 64'(wordErrs), 64'd0);
        checkOutput($sformatf("%s.busyAtDone", tag), 64'(busyAtDone), 64'd0);
    endtask

    task automatic checkModelResults(input string tag);
        checkOutput($sformatf("%s.total", tag), 64'(total_count), modelTotal);
        checkOutput($sformatf("%s.modeWord", tag), 64'(mode_word), 64'(modelWord));
        checkOutput($sformatf("%s.modeCount", tag), 64'(mode_count), 64'(modelCount));
        checkOutput($sformatf("%s.nonzero", tag), 64'(nonzero_bins), 64'(modelNz));
    endtask

    initial begin
        int          lat, vc, we;
        logic        bd;
        int          extraDone, extraBusy;
        logic [59:0] savedTotal;
        logic [11:0] savedWord;
        logic [47:0] savedCount;

        vecs[0] = '{nPairs: 0, w: '0, c: '0, expTotal: 60'd0, expWord: 12'h000,
                    expCount: 48'd0, expNz: 13'd0};
        vecs[1] = '{nPairs: 1, w: {12'h0, 12'h0, 12'h123}, c: {48'd0, 48'd0, 48'd8},
                    expTotal: 60'd8, expWord: 12'h123, expCount: 48'd8, expNz: NZ_EN ? 13'd1 : 13'd0};
        vecs[2] = '{nPairs: 3, w: {12'hFFF, 12'h010, 12'h020}, c: {48'd4, 48'd5, 48'd5},
                    expTotal: 60'd14, expWord: 12'h010, expCount: 48'd5, expNz: NZ_EN ? 13'd3 : 13'd0};

        clearMem();
        start = 1'b0;
        rst_n = 1'b0;
        #12;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.queryValid", 64'(query_valid), 64'd0);
        checkOutput("reset.queryWord", 64'(query_word), 64'd0);
        checkOutput("reset.total", 64'(total_count), 64'd0);
        checkOutput("reset.modeWord", 64'(mode_word), 64'd0);
        checkOutput("reset.modeCount", 64'(mode_count), 64'd0);
        checkOutput("reset.nonzero", 64'(nonzero_bins), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            clearMem();
            for (int p = 0; p < vecs[v].nPairs; p++) histMem[vecs[v].w[p]] = vecs[v].c[p];
            applyStimulus(1'b0, 1'b0, 1'b0, lat, vc, we, bd);
            checkScan($sformatf("vec%0d", v), lat, vc, we, bd);
            checkOutput($sformatf("vec%0d.total", v), 64'(total_count), 64'(vecs[v].expTotal));
            checkOutput($sformatf("vec%0d.modeWord", v), 64'(mode_word), 64'(vecs[v].expWord));
            checkOutput($sformatf("vec%0d.modeCount", v), 64'(mode_count), 64'(vecs[v].expCount));
            checkOutput($sformatf("vec%0d.nonzero", v), 64'(nonzero_bins), 64'(vecs[v].expNz));
            @(negedge clk);
            checkOutput($sformatf("vec%0d.donePulse", v), 64'(done), 64'd0);
        end

        // Random fills: small counts force many ties, wide counts stress the accumulator.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                case (r)
                    0: histMem[i] = 48'($urandom_range(0, 3));
                    1: histMem[i] = ($urandom_range(0, 7) == 0) ? 48'($urandom_range(1, 50)) : 48'd0;
                    default: histMem[i] = 48'({$urandom, $urandom});
                endcase
            end
            computeModel();
            applyStimulus(1'b0, 1'b0, 1'b0, lat, vc, we, bd);
            checkScan($sformatf("rand%0d", r), lat, vc, we, bd);
            checkModelResults($sformatf("rand%0d", r));
        end

        // start held high across the whole scan must yield exactly one sweep.
        clearMem();
        histMem[12'h7A5] = 48'd9;
        computeModel();
        applyStimulus(1'b1, 1'b0, 1'b0, lat, vc, we, bd);
        checkScan("held", lat, vc, we, bd);
        checkModelResults("held");
        extraDone = 0;
        extraBusy = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) extraDone++;
            if (busy || query_valid) extraBusy++;
        end
        checkOutput("held.extraDone", 64'(extraDone), 64'd0);
        checkOutput("held.extraBusy", 64'(extraBusy), 64'd0);

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < N; i++) histMem[i] = 48'($urandom_range(1, 20));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        checkOutput("midscan.busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstAsync.busy", 64'(busy), 64'd0);
        checkOutput("rstAsync.queryValid", 64'(query_valid), 64'd0);
        checkOutput("rstAsync.queryWord", 64'(query_word), 64'd0);
        checkOutput("rstAsync.total", 64'(total_count), 64'd0);
        checkOutput("rstAsync.modeWord", 64'(mode_word), 64'd0);
        checkOutput("rstAsync.modeCount", 64'(mode_count), 64'd0);
        checkOutput("rstAsync.nonzero", 64'(nonzero_bins), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("postRst.idleBusy", 64'(busy), 64'd0);
        checkOutput("postRst.idleQuery", 64'(query_valid), 64'd0);
        computeModel();
        applyStimulus(1'b0, 1'b0, 1'b0, lat, vc, we, bd);
        checkScan("postRst", lat, vc, we, bd);
        checkModelResults("postRst");

        // Back-to-back: start asserted in the done cycle launches the next scan.
        for (int i = 0; i < N; i++) histMem[i] = 48'($urandom_range(0, 1000));
        computeModel();
        applyStimulus(1'b0, 1'b0, 1'b1, lat, vc, we, bd);
        checkScan("b2b1", lat, vc, we, bd);
        checkModelResults("b2b1");
        savedTotal = total_count;
        savedWord  = mode_word;
        savedCount = mode_count;
        applyStimulus(1'b0, 1'b1, 1'b0, lat, vc, we, bd);
        checkScan("b2b2", lat, vc, we, bd);
        checkModelResults("b2b2");
        checkOutput("b2b2.sameTotal", 64'(total_count), 64'(savedTotal));
        checkOutput("b2b2.sameWord", 64'(mode_word), 64'(savedWord));
        checkOutput("b2b2.sameCount", 64'(mode_count), 64'(savedCount));

        $display("[TB] %0d tests run, %0d failed", testsRun, failed);
        $finish;
    end

endmodule
